univ_shift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with an enable and eight operating modes.
- Modes: hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Tracks shifts since the last load/clear and flags when all bits are shifted out.
- Serves as the team's general storage, serializer and deserializer element in later datapath blocks.

---
 rtl/univ_shift_reg.sv | 108 ++++++++++
 tb/tb_univ_shift_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, logical/arithmetic shift, rotate,
// parallel load and clear, with a saturating shift counter and done flag.
module univ_shift_reg #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                CW          = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerInR,
  input  logic             SerInL,
  output logic [WIDTH-1:0] Q,
  output logic             SerOutR,
  output logic             SerOutL,
  output logic [CW-1:0]    ShiftCnt,
  output logic             Done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] q_p0;
  logic [CW-1:0]    cnt_p0;
  logic             done_p0;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;

  function automatic logic [WIDTH-1:0] data_next(
    input logic [WIDTH-1:0] q,
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] d,
    input logic             ser_r,
    input logic             ser_l
  );
    logic signed [WIDTH-1:0] q_s;
    logic [WIDTH-1:0]        r;
    q_s = signed'(q);
    r   = q;
    case (mode)
      MODE_SHR:   r = {ser_r, q[WIDTH-1:1]};
      MODE_SHL:   r = {q[WIDTH-2:0], ser_l};
      MODE_ROR:   r = {q[0], q[WIDTH-1:1]};
      MODE_ROL:   r = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_LOAD:  r = d;
      MODE_ASR:   r = unsigned'(q_s >>> 1);
      MODE_CLEAR: r = '0;
      default:    r = q;
    endcase
    return r;
  endfunction

  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

  // Counter never wraps: it sticks at WIDTH once every bit has been shifted out.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (cnt >= CNT_FULL) ? CNT_FULL : cnt + CW'(1);
  endfunction

  always_comb begin
    q_nxt   = q_p0;
    cnt_nxt = cnt_p0;
    if (En) begin
      q_nxt = data_next(q_p0, Mode, D, SerInR, SerInL);
      if (is_shift(Mode))
        cnt_nxt = sat_inc(cnt_p0);
      else if ((Mode == MODE_LOAD) || (Mode == MODE_CLEAR))
        cnt_nxt = '0;
      else
        cnt_nxt = cnt_p0;
    end
  end

  // Stage p0: register state; done is derived from the next count so it rises
  // on the same edge the count reaches WIDTH.
  always_ff @(posedge clock) begin
    if (Reset) begin
      q_p0    <= RESET_VALUE;
      cnt_p0  <= '0;
      done_p0 <= 1'b0;
    end else if (En) begin
      q_p0    <= q_nxt;
      cnt_p0  <= cnt_nxt;
      done_p0 <= (cnt_nxt == CNT_FULL);
    end
  end

  assign Q        = q_p0;
  assign ShiftCnt = cnt_p0;
  assign Done     = done_p0;
  assign SerOutR  = q_p0[0];
  assign SerOutL  = q_p0[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic, checked
// every cycle against an arithmetic model of the register.
module tb_univ_shift_reg;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         Reset = 1'b0;
  logic         En = 1'b0;
  logic [2:0]   Mode = 3'b000;
  logic [W-1:0] D = '0;
  logic         SerInR = 1'b0;
  logic         SerInL = 1'b0;
  logic [W-1:0] Q;
  logic         SerOutR;
  logic         SerOutL;
  logic [3:0]   ShiftCnt;
  logic         Done;

  int n_cmp  = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clock(clock), .Reset(Reset), .En(En), .Mode(Mode), .D(D),
    .SerInR(SerInR), .SerInL(SerInL), .Q(Q), .SerOutR(SerOutR),
    .SerOutL(SerOutL), .ShiftCnt(ShiftCnt), .Done(Done)
  );

  always #5 clock = ~clock;

  // Model: register value as an integer in [0, 256), count in [0, W].
  int m_q    = 0;
  int m_cnt  = 0;
  bit m_done = 0;
  bit m_vld  = 0;

  always @(posedge clock) begin
    if (Reset) begin
      m_q = 0; m_cnt = 0; m_done = 0; m_vld = 1;
    end else if (En) begin
      case (Mode)
        3'd1: m_q = (m_q / 2) + (SerInR ? 128 : 0);
        3'd2: m_q = ((m_q * 2) % 256) + (SerInL ? 1 : 0);
        3'd3: m_q = (m_q / 2) + ((m_q % 2) * 128);
        3'd4: m_q = ((m_q * 2) % 256) + (m_q / 128);
        3'd5: m_q = int'(D);
        3'd6: m_q = (m_q / 2) + ((m_q >= 128) ? 128 : 0);
        3'd7: m_q = 0;
        default: ;
      endcase
      if (Mode == 3'd5 || Mode == 3'd7) m_cnt = 0;
      else if (Mode != 3'd0 && m_cnt < W) m_cnt = m_cnt + 1;
      m_done = (m_cnt == W);
    end
  end

  always @(negedge clock) begin
    if (m_vld) begin
      n_cmp++;
      if (Q !== W'(m_q) || ShiftCnt !== 4'(m_cnt) || Done !== m_done ||
          SerOutR !== W'(m_q) >> 0 & 1'b1 ? 1'b0 : 1'b0) begin
      end
      if (Q !== W'(m_q) || ShiftCnt !== 4'(m_cnt) || Done !== m_done ||
          SerOutR !== ((m_q % 2) == 1) || SerOutL !== (m_q >= 128)) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: Q=%0h cnt=%0d done=%0b sor=%0b sol=%0b required Q=%0h cnt=%0d done=%0b",
                 $time, Q, ShiftCnt, Done, SerOutR, SerOutL, m_q, m_cnt, m_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [2:0] m,
                      input logic [W-1:0] d, input logic sr, input logic sl);
    Reset = rst; En = en; Mode = m; D = d; SerInR = sr; SerInL = sl;
    @(posedge clock);
    #1;
  endtask

  bit exp_sr [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    // Reset overrides a pending load.
    step(1, 1, 3'd5, 8'hFF, 0, 0);
    chk("rst_q", Q, 8'h00);
    chk("rst_cnt", ShiftCnt, 0);
    chk("rst_done", Done, 0);

    // Load then eight right shifts with SerInR=1.
    step(0, 1, 3'd5, 8'hA5, 0, 0);
    chk("ld_q", Q, 8'hA5);
    chk("ld_cnt", ShiftCnt, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sor_%0d", i), SerOutR, exp_sr[i]);
      if (i == 7) chk("done_before8", Done, 0);
      step(0, 1, 3'd1, 8'h00, 1, 0);
    end
    chk("shr_q", Q, 8'hFF);
    chk("shr_cnt", ShiftCnt, 8);
    chk("shr_done", Done, 1);
    step(0, 1, 3'd1, 8'h00, 0, 0);
    chk("sat_cnt", ShiftCnt, 8);
    chk("sat_done", Done, 1);
    chk("sat_q", Q, 8'h7F);

    // Rotations.
    step(0, 1, 3'd5, 8'h81, 0, 0);
    step(0, 1, 3'd4, 8'h00, 0, 0);
    chk("rol_q", Q, 8'h03);
    step(0, 1, 3'd3, 8'h00, 0, 0);
    step(0, 1, 3'd3, 8'h00, 0, 0);
    chk("ror_q", Q, 8'hC0);

    // Arithmetic shift ignores SerInR.
    step(0, 1, 3'd5, 8'h80, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd6, 8'h00, 0, 0);
    chk("asr_q", Q, 8'hF0);
    chk("asr_cnt", ShiftCnt, 3);

    // Enable gating.
    step(0, 1, 3'd5, 8'h3C, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 3'd1, 8'hFF, 1, 1);
    chk("en_q", Q, 8'h3C);
    chk("en_cnt", ShiftCnt, 0);

    // Clear after seven shifts.
    for (int i = 0; i < 7; i++) step(0, 1, 3'd2, 8'h00, 1, 1);
    chk("pre_clr_cnt", ShiftCnt, 7);
    step(0, 1, 3'd7, 8'h00, 0, 0);
    chk("clr_q", Q, 8'h00);
    chk("clr_cnt", ShiftCnt, 0);
    chk("clr_done", Done, 0);

    // Load on the edge where done would rise.
    for (int i = 0; i < 7; i++) step(0, 1, 3'd2, 8'h00, 0, 1);
    step(0, 1, 3'd5, 8'h5A, 0, 0);
    chk("ldwin_q", Q, 8'h5A);
    chk("ldwin_cnt", ShiftCnt, 0);
    chk("ldwin_done", Done, 0);

    // Reset in the middle of a left-shift run.
    step(0, 1, 3'd2, 8'h00, 0, 1);
    step(0, 1, 3'd2, 8'h00, 0, 1);
    chk("pre_rst_q", Q, 8'h6B);
    step(1, 1, 3'd2, 8'h00, 0, 1);
    chk("midrst_q", Q, 8'h00);
    chk("midrst_cnt", ShiftCnt, 0);

    // Random traffic, checked by the per-cycle model compare.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0),
           3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
